// File: rtl/mem_port_arbiter.sv
// Arbitrates an instruction-fetch port and a cache port onto one four-phase memory port.
// Arbitration is round-robin. A wait counter bounds each memory access. On a timeout the
// requester receives zero data, and err is set and held until reset.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   instr_req/addr, instr_ack/data   instruction-fetch four-phase port
//   cache_req/addr, cache_ack/data   cache four-phase port
//   mem_req/addr/ph0, mem_ack/data   four-phase memory port; ph0 tags the data destination
//   err                              sticky timeout flag
module mem_port_arbiter #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_req,
  input  logic [ADDR_W-1:0] instr_addr,
  output logic              instr_ack,
  output logic [DATA_W-1:0] instr_data,
  input  logic              cache_req,
  input  logic [ADDR_W-1:0] cache_addr,
  output logic              cache_ack,
  output logic [DATA_W-1:0] cache_data,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [1:0]        mem_ph0,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_data,
  output logic              err
);

  localparam logic [1:0] TagInstr = 2'b10;
  localparam logic [1:0] TagCache = 2'b00;
  localparam logic [1:0] TagIdle  = 2'b01;
  localparam logic [7:0] WaitLast = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {StIdle, StMreq, StMrel, StAck, StDrop} state_e;

  state_e     state;
  logic [7:0] wait_cnt;
  logic       last_instr;   // 1: instr was granted most recently
  logic       grant_instr;  // owner of the transaction in flight
  logic       pick_instr;

  // Instr wins unless cache also requests and instr had the previous grant.
  always_comb begin
    pick_instr = instr_req && (!cache_req || !last_instr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= StIdle;
      wait_cnt    <= '0;
      last_instr  <= 1'b0;
      grant_instr <= 1'b0;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      mem_ph0     <= TagIdle;
      instr_ack   <= 1'b0;
      cache_ack   <= 1'b0;
      instr_data  <= '0;
      cache_data  <= '0;
      err         <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (instr_req || cache_req) begin
            grant_instr <= pick_instr;
            last_instr  <= pick_instr;
            mem_req     <= 1'b1;
            mem_addr    <= pick_instr ? instr_addr : cache_addr;
            mem_ph0     <= pick_instr ? TagInstr : TagCache;
            wait_cnt    <= '0;
            state       <= StMreq;
          end
        end
        StMreq: begin
          if (mem_ack) begin
            if (grant_instr) instr_data <= mem_data;
            else             cache_data <= mem_data;
            mem_req <= 1'b0;
            state   <= StMrel;
          end else if (wait_cnt == WaitLast) begin
            // Timed out: hand the requester a zero word and flag it.
            if (grant_instr) instr_data <= '0;
            else             cache_data <= '0;
            err     <= 1'b1;
            mem_req <= 1'b0;
            state   <= StMrel;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        StMrel: begin
          // mem_addr is left as-is; only the tag returns to idle.
          if (!mem_ack) begin
            mem_ph0 <= TagIdle;
            if (grant_instr) instr_ack <= 1'b1;
            else             cache_ack <= 1'b1;
            state <= StAck;
          end
        end
        StAck: begin
          // A req dropped early is simply seen low here, so ack lasts one cycle.
          if (grant_instr ? !instr_req : !cache_req) begin
            instr_ack <= 1'b0;
            cache_ack <= 1'b0;
            state     <= StDrop;
          end
        end
        StDrop: begin
          state <= StIdle;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          instr_req, cache_req, mem_ack;
  logic [AW-1:0] instr_addr, cache_addr, mem_addr;
  logic [DW-1:0] instr_data, cache_data, mem_data;
  logic          instr_ack, cache_ack, mem_req, err;
  logic [1:0]    mem_ph0;

  int            checks = 0;
  int            errors = 0;
  int            mem_lat;       // memory response delay in cycles; 0 = never answers
  logic [DW-1:0] rdata_i, rdata_c;

  typedef struct packed {logic [1:0] tag; logic [AW-1:0] addr;} grant_t;
  typedef struct {bit is_cache; logic [DW-1:0] data; logic err;} resp_t;

  grant_t grant_q[$];
  resp_t  resp_q[$];

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .instr_req  (instr_req),
    .instr_addr (instr_addr),
    .instr_ack  (instr_ack),
    .instr_data (instr_data),
    .cache_req  (cache_req),
    .cache_addr (cache_addr),
    .cache_ack  (cache_ack),
    .cache_data (cache_data),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ph0    (mem_ph0),
    .mem_ack    (mem_ack),
    .mem_data   (mem_data),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
  endtask

  // Requester side: drop each req once its ack is seen, wait until both acks are low.
  task automatic serve(input bit do_i, input bit do_c);
    bit done_i = !do_i;
    bit done_c = !do_c;
    int n = 0;
    while (!(done_i && done_c && !instr_ack && !cache_ack) && n < 300) begin
      @(negedge clk);
      n++;
      if (instr_ack && instr_req) begin instr_req = 1'b0; done_i = 1'b1; end
      if (cache_ack && cache_req) begin cache_req = 1'b0; done_c = 1'b1; end
    end
    if (n >= 300) fail_now("serve handshake timeout");
  endtask

  // Memory model: answer mem_lat cycles after mem_req rises, release when mem_req drops.
  initial begin
    int mem_wait = 0;
    mem_ack  = 1'b0;
    mem_data = '0;
    forever begin
      @(negedge clk);
      if (!mem_req) begin
        mem_ack  = 1'b0;
        mem_wait = 0;
      end else if (!mem_ack) begin
        mem_wait++;
        if (mem_lat != 0 && mem_wait >= mem_lat) begin
          mem_ack  = 1'b1;
          mem_data = (mem_ph0 == 2'b10) ? rdata_i : rdata_c;
        end
      end
    end
  end

  // Monitor: compare each new memory grant and each new requester ack against the queues.
  initial begin
    logic   pr = 1'b0, pi = 1'b0, pc = 1'b0;
    grant_t g;
    resp_t  r;
    forever begin
      @(negedge clk);
      if (mem_req && !pr) begin
        if (grant_q.size() == 0) fail_now("unexpected mem_req");
        else begin
          g = grant_q.pop_front();
          check("grant mem_ph0", 32'(mem_ph0), 32'(g.tag));
          check("grant mem_addr", 32'(mem_addr), 32'(g.addr));
        end
      end
      if ((instr_ack && !pi) || (cache_ack && !pc)) begin
        if (resp_q.size() == 0) fail_now("unexpected ack");
        else begin
          r = resp_q.pop_front();
          check("cache_ack", 32'(cache_ack), 32'(r.is_cache));
          check("instr_ack", 32'(instr_ack), 32'(!r.is_cache));
          check("ack data", 32'(r.is_cache ? cache_data : instr_data), 32'(r.data));
          check("ack err", 32'(err), 32'(r.err));
          check("ack mem_ph0 idle", 32'(mem_ph0), 32'(2'b01));
        end
      end
      if (instr_ack && cache_ack) fail_now("both acks high");
      pr = mem_req;
      pi = instr_ack;
      pc = cache_ack;
    end
  end

  initial begin
    #200000;
    $display("FAIL global time limit");
    $fatal(1, "time limit");
  end

  initial begin
    int n;
    rst        = 1'b1;
    instr_req  = 1'b0;
    cache_req  = 1'b0;
    instr_addr = '0;
    cache_addr = '0;
    mem_lat    = 2;
    rdata_i    = '0;
    rdata_c    = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    check("reset mem_req", 32'(mem_req), 32'(0));
    check("reset mem_addr", 32'(mem_addr), 32'(0));
    check("reset mem_ph0", 32'(mem_ph0), 32'(2'b01));
    check("reset instr_ack", 32'(instr_ack), 32'(0));
    check("reset cache_ack", 32'(cache_ack), 32'(0));
    check("reset instr_data", 32'(instr_data), 32'(0));
    check("reset cache_data", 32'(cache_data), 32'(0));
    check("reset err", 32'(err), 32'(0));

    // Single instr read, memory answers after 3 cycles.
    mem_lat = 3; rdata_i = 16'hBEEF; instr_addr = 16'h0040;
    grant_q.push_back('{2'b10, 16'h0040});
    resp_q.push_back('{1'b0, 16'hBEEF, 1'b0});
    instr_req = 1'b1;
    @(posedge clk); #1;
    check("req to mem_req latency", 32'(mem_req), 32'(1));
    serve(1'b1, 1'b0);
    check("cache_ack idle", 32'(cache_ack), 32'(0));
    check("cache_data untouched", 32'(cache_data), 32'(0));

    // Simultaneous pairs after reset: instr, cache, instr, cache.
    pulse_reset();
    mem_lat = 2;
    rdata_i = 16'h1111; rdata_c = 16'h2222; instr_addr = 16'h0100; cache_addr = 16'h0200;
    grant_q.push_back('{2'b10, 16'h0100}); resp_q.push_back('{1'b0, 16'h1111, 1'b0});
    grant_q.push_back('{2'b00, 16'h0200}); resp_q.push_back('{1'b1, 16'h2222, 1'b0});
    instr_req = 1'b1; cache_req = 1'b1;
    serve(1'b1, 1'b1);
    idle(2);
    rdata_i = 16'h3333; rdata_c = 16'h4444; instr_addr = 16'h0300; cache_addr = 16'h0400;
    grant_q.push_back('{2'b10, 16'h0300}); resp_q.push_back('{1'b0, 16'h3333, 1'b0});
    grant_q.push_back('{2'b00, 16'h0400}); resp_q.push_back('{1'b1, 16'h4444, 1'b0});
    instr_req = 1'b1; cache_req = 1'b1;
    serve(1'b1, 1'b1);
    idle(2);

    // Timeout with TIMEOUT=4: mem_req held exactly 4 cycles, zero data, err set.
    mem_lat = 0; cache_addr = 16'h0500;
    grant_q.push_back('{2'b00, 16'h0500}); resp_q.push_back('{1'b1, 16'h0000, 1'b1});
    cache_req = 1'b1;
    @(posedge clk); #1;
    n = 0;
    while (mem_req && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("timeout mem_req cycles", 32'(n), 32'(4));
    serve(1'b0, 1'b1);
    check("err after timeout", 32'(err), 32'(1));
    idle(2);

    // Good transaction after timeout keeps err high.
    mem_lat = 2; rdata_i = 16'h5A5A; instr_addr = 16'h0600;
    grant_q.push_back('{2'b10, 16'h0600}); resp_q.push_back('{1'b0, 16'h5A5A, 1'b1});
    instr_req = 1'b1;
    serve(1'b1, 1'b0);
    idle(2);

    // Early drop: instr_req falls during MREQ, ack still pulses for one cycle.
    mem_lat = 3; rdata_i = 16'h7777; instr_addr = 16'h0700;
    grant_q.push_back('{2'b10, 16'h0700}); resp_q.push_back('{1'b0, 16'h7777, 1'b1});
    instr_req = 1'b1;
    @(negedge clk) instr_req = 1'b0;
    n = 0;
    while (!instr_ack && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!instr_ack) fail_now("early drop ack never seen");
    n = 0;
    while (instr_ack && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("early drop ack width", 32'(n), 32'(1));
    idle(2);

    // Back-to-back cache: mem_req returns 2 cycles after cache_ack falls.
    mem_lat = 2; rdata_c = 16'h8888; cache_addr = 16'h0800;
    grant_q.push_back('{2'b00, 16'h0800}); resp_q.push_back('{1'b1, 16'h8888, 1'b1});
    grant_q.push_back('{2'b00, 16'h0900}); resp_q.push_back('{1'b1, 16'h9999, 1'b1});
    cache_req = 1'b1;
    n = 0;
    while (!cache_ack && n < 50) begin
      @(negedge clk);
      n++;
    end
    cache_req = 1'b0;
    n = 0;
    while (cache_ack && n < 50) begin
      @(negedge clk);
      n++;
    end
    cache_addr = 16'h0900; rdata_c = 16'h9999; cache_req = 1'b1;
    n = 0;
    while (!mem_req && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check("back-to-back re-request gap", 32'(n), 32'(2));
    serve(1'b0, 1'b1);
    idle(2);

    // Reset during MREQ aborts with no ack and clears err.
    mem_lat = 0; instr_addr = 16'h0A00;
    grant_q.push_back('{2'b10, 16'h0A00});
    instr_req = 1'b1;
    @(posedge clk); #1;
    check("pre-reset mem_req", 32'(mem_req), 32'(1));
    @(negedge clk) begin rst = 1'b1; instr_req = 1'b0; end
    @(posedge clk); #1;
    check("mid-op reset mem_req", 32'(mem_req), 32'(0));
    check("mid-op reset mem_ph0", 32'(mem_ph0), 32'(2'b01));
    check("mid-op reset acks", 32'({instr_ack, cache_ack}), 32'(0));
    check("mid-op reset err", 32'(err), 32'(0));
    @(negedge clk) rst = 1'b0;
    idle(3);
    check("no grant after reset without req", 32'(mem_req), 32'(0));

    // Last grant was instr before reset; a fresh pair must still start with instr.
    mem_lat = 2;
    rdata_i = 16'hB0B0; rdata_c = 16'hC0C0; instr_addr = 16'h0B00; cache_addr = 16'h0C00;
    grant_q.push_back('{2'b10, 16'h0B00}); resp_q.push_back('{1'b0, 16'hB0B0, 1'b0});
    grant_q.push_back('{2'b00, 16'h0C00}); resp_q.push_back('{1'b1, 16'hC0C0, 1'b0});
    instr_req = 1'b1; cache_req = 1'b1;
    serve(1'b1, 1'b1);
    idle(3);

    check("grant queue drained", 32'(grant_q.size()), 32'(0));
    check("resp queue drained", 32'(resp_q.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
